// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst/response encodings, ID width, the read
// arbiter state type and a constant-evaluable ceil(log2) helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_ID_W       = 4;

  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_AR   = 2'b01,
    RD_R    = 2'b10,
    RD_RET  = 2'b11
  } rd_arb_state_t;

  // ceil(log2(value)); clog2(1) = 0. Intended for elaboration-time sizing.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read address + read data channels as one bundle. The arbiter is the
// master; the interconnect/slave model attaches to the slave modport.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import axi_pkg::*;

  // Read address channel
  logic [AXI_ID_W-1:0] arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  // Read data channel
  logic [AXI_ID_W-1:0] rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past the last
// granted index and wraps modulo NCLI; the first requester found wins.
module rr_arbiter
  import axi_pkg::*;
#(
  parameter  int NCLI  = 2,
  localparam int IDX_W = (NCLI > 1) ? clog2(NCLI) : 1
) (
  input  logic [NCLI-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NCLI-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int cand_s;

  // Walk candidates from lowest to highest priority so the highest-priority
  // requester is the last (winning) assignment.
  always_comb begin
    gnt_idx = '0;
    cand_s  = 0;
    for (int off = NCLI; off >= 1; off--) begin
      cand_s = int'(last_grant) + off;
      cand_s = (cand_s >= NCLI) ? (cand_s - NCLI) : cand_s;
      gnt_idx = req[IDX_W'(cand_s)] ? IDX_W'(cand_s) : gnt_idx;
    end
  end

  // One-hot grant, all-zero when nobody requests.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NCLI; i++) begin
      gnt[i] = (|req) && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-client AXI4 read-burst arbiter and line assembler. Grants one client at
// a time round-robin, issues one INCR burst per grant, packs the beats into
// a line buffer and returns the line with a one-cycle valid and error flag.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter  int NCLI      = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int BURST_LEN = 4,
  localparam int LINE_W    = BURST_LEN * DATA_W
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NCLI-1:0]        cli_ren,
  input  logic [NCLI*ADDR_W-1:0] cli_raddr,
  output logic [NCLI-1:0]        cli_rrdy,
  output logic [NCLI-1:0]        cli_rvalid,
  output logic [NCLI-1:0]        cli_rerr,
  output logic [LINE_W-1:0]      cli_rdata,
  axi_rd_arbiter_if.master       axi
);

  localparam int IDX_W = (NCLI > 1) ? clog2(NCLI) : 1;
  localparam int CNT_W = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
  localparam int OFF_W = clog2(LINE_W / 8);
  localparam int SIZE  = clog2(DATA_W / 8);

  // Line-aligned address: low bits covering one whole line are cleared.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BURST_LEN - 1);

  rd_arb_state_t       state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [NCLI-1:0]     cli_rvalid_q, cli_rvalid_d;
  logic [NCLI-1:0]     cli_rerr_q, cli_rerr_d;
  logic                cli_rrdy_q, cli_rrdy_d;

  logic [NCLI-1:0]     gnt_s;
  logic [IDX_W-1:0]    gnt_idx_s;
  logic [ADDR_W-1:0]   raddr_sel_s;
  logic [NCLI-1:0]     grant_oh_s;
  logic                beat_s;
  logic                id_match_s;
  logic                last_by_cnt_s;
  logic                burst_end_s;
  logic                beat_err_s;

  rr_arbiter #(
    .NCLI (NCLI)
  ) u_rr_arbiter (
    .req        (cli_ren),
    .last_grant (last_grant_q),
    .gnt        (gnt_s),
    .gnt_idx    (gnt_idx_s)
  );

  // Pick the address of the client the arbiter would grant this cycle.
  always_comb begin
    raddr_sel_s = '0;
    for (int i = 0; i < NCLI; i++) begin
      raddr_sel_s = raddr_sel_s | ({ADDR_W{gnt_s[i]}} & cli_raddr[i*ADDR_W +: ADDR_W]);
    end
  end

  // One-hot view of the latched grant, used to steer the line return.
  always_comb begin
    grant_oh_s = '0;
    for (int i = 0; i < NCLI; i++) begin
      grant_oh_s[i] = (grant_q == IDX_W'(i));
    end
  end

  // Decode the current read-data beat. A beat whose ID does not belong to
  // the granted client is consumed but never counts toward the line, so the
  // beat-count end condition only fires on matching beats.
  always_comb begin
    beat_s        = axi.rvalid & rready_q;
    id_match_s    = (axi.rid == AXI_ID_W'(grant_q));
    last_by_cnt_s = id_match_s & (cnt_q == CNT_LAST);
    burst_end_s   = beat_s & (axi.rlast | last_by_cnt_s);
    beat_err_s    = (~id_match_s)
                  | (axi.rresp != AXI_RESP_OKAY)
                  | (axi.rlast != last_by_cnt_s);
  end

  // Next-state and registered-output computation for the burst FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    cli_rvalid_d = '0;
    cli_rerr_d   = '0;
    cli_rrdy_d   = cli_rrdy_q;

    case (state_q)
      RD_IDLE: begin
        if (|gnt_s) begin
          state_d    = RD_AR;
          grant_d    = gnt_idx_s;
          addr_d     = raddr_sel_s & ALIGN_MASK;
          line_d     = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
          arvalid_d  = 1'b1;
          cli_rrdy_d = 1'b0;
        end else begin
          cli_rrdy_d = 1'b1;
        end
      end

      RD_AR: begin
        if (axi.arready) begin
          state_d   = RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      RD_R: begin
        if (beat_s) begin
          for (int k = 0; k < BURST_LEN; k++) begin
            line_d[k*DATA_W +: DATA_W] = (id_match_s && (cnt_q == CNT_W'(k)))
                                       ? axi.rdata
                                       : line_q[k*DATA_W +: DATA_W];
          end
          cnt_d = id_match_s ? (cnt_q + CNT_W'(1)) : cnt_q;
          err_d = err_q | beat_err_s;
          if (burst_end_s) begin
            state_d      = RD_RET;
            rready_d     = 1'b0;
            cli_rvalid_d = grant_oh_s;
            cli_rerr_d   = grant_oh_s & {NCLI{err_q | beat_err_s}};
          end else begin
            rready_d = 1'b1;
          end
        end else begin
          rready_d = 1'b1;
        end
      end

      RD_RET: begin
        state_d      = RD_IDLE;
        last_grant_d = grant_q;
        cli_rrdy_d   = 1'b1;
      end

      default: begin
        state_d    = RD_IDLE;
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
        cli_rrdy_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset mid-burst
  // drops the transfer without returning a line.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= RD_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NCLI - 1);
      addr_q       <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      cli_rvalid_q <= '0;
      cli_rerr_q   <= '0;
      cli_rrdy_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      cli_rvalid_q <= cli_rvalid_d;
      cli_rerr_q   <= cli_rerr_d;
      cli_rrdy_q   <= cli_rrdy_d;
    end
  end

  assign axi.arid    = AXI_ID_W'(grant_q);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(BURST_LEN - 1);
  assign axi.arsize  = 3'(SIZE);
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign cli_rrdy   = {NCLI{cli_rrdy_q}};
  assign cli_rvalid = cli_rvalid_q;
  assign cli_rerr   = cli_rerr_q;
  assign cli_rdata  = line_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter (NCLI=2, DATA_W=32, BURST_LEN=4):
// table of single-line transactions plus fairness, backpressure and
// reset-mid-burst sequences.
module tb_axi_rd_arbiter;

  localparam int NCLI   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BL     = 4;
  localparam int LINE_W = BL * DATA_W;

  typedef struct {
    int          cli;
    logic [31:0] addr;
    int          nbeats;
    logic [31:0] data [5];
    logic [3:0]  rid  [5];
    logic [1:0]  resp [5];
    logic [31:0] exp_addr;
    logic [127:0] exp_line;
    logic        exp_err;
  } vec_t;

  logic                   aclk;
  logic                   areset;
  logic [NCLI-1:0]        cli_ren;
  logic [NCLI*ADDR_W-1:0] cli_raddr;
  logic [NCLI-1:0]        cli_rrdy;
  logic [NCLI-1:0]        cli_rvalid;
  logic [NCLI-1:0]        cli_rerr;
  logic [LINE_W-1:0]      cli_rdata;

  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_rd_arbiter #(
    .NCLI      (NCLI),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BL)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cli_ren    (cli_ren),
    .cli_raddr  (cli_raddr),
    .cli_rrdy   (cli_rrdy),
    .cli_rvalid (cli_rvalid),
    .cli_rerr   (cli_rerr),
    .cli_rdata  (cli_rdata),
    .axi        (axi)
  );

  int   n_pass;
  int   n_total;
  vec_t vecs [5];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic wait_arvalid();
    int n;
    n = 0;
    while (axi.arvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("arvalid_seen", axi.arvalid, 1'b1);
  endtask

  // Accept the AR at the current negedge, then return 4 clean beats with the
  // given ID. Returns at the negedge of the line-return cycle.
  task automatic serve(input logic [3:0] id, input logic [31:0] base);
    axi.arready = 1'b1;
    @(negedge aclk);
    axi.arready = 1'b0;
    for (int k = 0; k < BL; k++) begin
      axi.rvalid = 1'b1;
      axi.rid    = id;
      axi.rdata  = base + 32'(k);
      axi.rresp  = 2'b00;
      axi.rlast  = (k == BL - 1);
      @(negedge aclk);
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int ar_wait, input bit gaps);
    int          cyc;
    int          early;
    int          ar_bad;
    logic [1:0]  oh;
    oh     = 2'b01 << v.cli;
    early  = 0;
    ar_bad = 0;
    @(negedge aclk);
    chk("rrdy_idle", cli_rrdy, 2'b11);
    cli_ren = 2'b00;
    cli_ren[v.cli] = 1'b1;
    cli_raddr[v.cli*ADDR_W +: ADDR_W] = v.addr;
    cyc = 1;
    @(negedge aclk);
    cyc++;
    chk("arvalid_lat", axi.arvalid, 1'b1);
    chk("araddr", axi.araddr, v.exp_addr);
    chk("arid", axi.arid, 4'(v.cli));
    chk("arlen", axi.arlen, 8'd3);
    chk("arsize", axi.arsize, 3'd2);
    chk("arburst", axi.arburst, 2'b01);
    chk("rrdy_busy", cli_rrdy, 2'b00);
    for (int i = 0; i < ar_wait; i++) begin
      axi.arready = 1'b0;
      @(negedge aclk);
      cyc++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== v.exp_addr) ar_bad++;
    end
    axi.arready = 1'b1;
    @(negedge aclk);
    cyc++;
    axi.arready = 1'b0;
    chk("arvalid_drop", axi.arvalid, 1'b0);
    chk("rready", axi.rready, 1'b1);
    for (int k = 0; k < v.nbeats; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = v.data[k];
      axi.rid    = v.rid[k];
      axi.rresp  = v.resp[k];
      axi.rlast  = (k == v.nbeats - 1);
      @(negedge aclk);
      cyc++;
      if (k != v.nbeats - 1 && cli_rvalid !== 2'b00) early++;
      if (gaps && k != v.nbeats - 1) begin
        axi.rvalid = 1'b0;
        axi.rdata  = 32'hFFFF_FFFF;
        axi.rlast  = 1'b1;
        @(negedge aclk);
        cyc++;
        if (cli_rvalid !== 2'b00) early++;
      end
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    chk("ar_stable", 32'(ar_bad), 32'd0);
    chk("no_early_rvalid", 32'(early), 32'd0);
    chk("cli_rvalid", cli_rvalid, oh);
    chk("cli_rerr", cli_rerr, v.exp_err ? oh : 2'b00);
    chk("cli_rdata", cli_rdata, v.exp_line);
    if (ar_wait == 0 && !gaps) chk("latency", 32'(cyc), 32'(3 + v.nbeats));
    cli_ren = 2'b00;
    @(negedge aclk);
    chk("rvalid_one_cycle", cli_rvalid, 2'b00);
    chk("rrdy_back", cli_rrdy, 2'b11);
    chk("rdata_held", cli_rdata, v.exp_line);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    areset      = 1'b1;
    cli_ren     = '0;
    cli_raddr   = '0;
    axi.arready = 1'b0;
    axi.rid     = 4'd0;
    axi.rdata   = 32'd0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;

    vecs[0].cli = 1; vecs[0].addr = 32'h1C00_0014; vecs[0].nbeats = 4;
    vecs[0].data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
    vecs[0].rid  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    vecs[0].resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[0].exp_addr = 32'h1C00_0010;
    vecs[0].exp_line = 128'h000000A3_000000A2_000000A1_000000A0;
    vecs[0].exp_err  = 1'b0;

    vecs[1].cli = 0; vecs[1].addr = 32'h0000_1234; vecs[1].nbeats = 4;
    vecs[1].data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0};
    vecs[1].rid  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    vecs[1].resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1].exp_addr = 32'h0000_1230;
    vecs[1].exp_line = 128'h44444444_33333333_22222222_11111111;
    vecs[1].exp_err  = 1'b0;

    // SLVERR on beat 2: data still stored, error reported
    vecs[2].cli = 1; vecs[2].addr = 32'h8000_003F; vecs[2].nbeats = 4;
    vecs[2].data = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'h0};
    vecs[2].rid  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    vecs[2].resp = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    vecs[2].exp_addr = 32'h8000_0030;
    vecs[2].exp_line = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
    vecs[2].exp_err  = 1'b1;

    // Early rlast on beat 1: slices 2..3 stay zero
    vecs[3].cli = 0; vecs[3].addr = 32'h0000_0040; vecs[3].nbeats = 2;
    vecs[3].data = '{32'hCAFE_0000, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0};
    vecs[3].rid  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    vecs[3].resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[3].exp_addr = 32'h0000_0040;
    vecs[3].exp_line = 128'h00000000_00000000_CAFE0001_CAFE0000;
    vecs[3].exp_err  = 1'b1;

    // Foreign-ID beat in position 1 is discarded, error reported
    vecs[4].cli = 1; vecs[4].addr = 32'h0000_0108; vecs[4].nbeats = 5;
    vecs[4].data = '{32'h5A5A_0000, 32'hBADB_AD00, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003};
    vecs[4].rid  = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd1};
    vecs[4].resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[4].exp_addr = 32'h0000_0100;
    vecs[4].exp_line = 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000;
    vecs[4].exp_err  = 1'b1;

    // Reset values
    repeat (3) @(negedge aclk);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_rready", axi.rready, 1'b0);
    chk("rst_cli_rvalid", cli_rvalid, 2'b00);
    chk("rst_cli_rerr", cli_rerr, 2'b00);
    chk("rst_cli_rdata", cli_rdata, 128'd0);
    chk("rst_cli_rrdy", cli_rrdy, 2'b11);
    areset = 1'b0;

    // Table-driven single-line transactions
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], 0, 1'b0);
    end

    // Backpressure: arready low 5 cycles, rvalid 1,0,1,0,...
    run_vec(vecs[1], 5, 1'b1);

    // Fairness: both clients request continuously from reset
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    cli_raddr = {32'h0000_2000, 32'h0000_1000};
    cli_ren   = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wait_arvalid();
      chk("fair_arid", axi.arid, 4'(b % 2));
      chk("fair_araddr", axi.araddr, (b % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      serve(axi.arid, 32'h100 * 32'(b));
      chk("fair_rvalid", cli_rvalid, (b % 2 == 0) ? 2'b01 : 2'b10);
    end
    cli_ren = 2'b00;
    @(negedge aclk);

    // Reset mid-burst. First leave last_grant at 0 so that only a proper
    // reset of last_grant makes client 0 win the following contest.
    cli_ren = 2'b01;
    wait_arvalid();
    serve(4'd0, 32'h300);
    chk("pre_rvalid", cli_rvalid, 2'b01);
    cli_ren = 2'b00;
    @(negedge aclk);
    cli_ren = 2'b10;
    wait_arvalid();
    chk("mid_arid", axi.arid, 4'd1);
    axi.arready = 1'b1;
    @(negedge aclk);
    axi.arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi.rvalid = 1'b1;
      axi.rid    = 4'd1;
      axi.rdata  = 32'h7700_0000 + 32'(k);
      axi.rresp  = 2'b00;
      axi.rlast  = 1'b0;
      @(negedge aclk);
    end
    axi.rvalid = 1'b0;
    cli_ren    = 2'b00;
    areset     = 1'b1;
    @(negedge aclk);
    chk("mid_rst_arvalid", axi.arvalid, 1'b0);
    chk("mid_rst_rready", axi.rready, 1'b0);
    chk("mid_rst_rrdy", cli_rrdy, 2'b11);
    chk("mid_rst_rvalid", cli_rvalid, 2'b00);
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_rvalid", cli_rvalid, 2'b00);
    cli_ren = 2'b11;
    wait_arvalid();
    chk("post_rst_arid", axi.arid, 4'd0);
    serve(4'd0, 32'h400);
    chk("post_rst_line_rvalid", cli_rvalid, 2'b01);
    chk("post_rst_line", cli_rdata, 128'h00000403_00000402_00000401_00000400);
    cli_ren = 2'b00;
    @(negedge aclk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
